// File: rtl/run_seq_detector.sv
// run_seq_detector: detects ascending runs 1^RUN_MIN, 2^RUN_MIN, ... STAGES^RUN_MIN
// on a sampled symbol stream, with strict/relaxed run length and a saturating hit count.
module run_seq_detector #(
  parameter int unsigned SYM_W   = 2,
  parameter int unsigned STAGES  = 3,
  parameter int unsigned RUN_MIN = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [SYM_W-1:0]                               num,
  input  logic                                           en,
  input  logic                                           strict,
  input  logic                                           clr,
  output logic                                           ans,
  output logic [CNT_W-1:0]                               hit_cnt,
  output logic [((STAGES > 1) ? $clog2(STAGES) : 1)-1:0] cur_stage
);

  localparam int unsigned STG_W = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int unsigned RUN_W = $clog2(RUN_MIN + 1);
  localparam int unsigned EXP_W = SYM_W + 1;

  logic [STG_W-1:0] stg, stg_n;
  logic [RUN_W-1:0] run, run_n;
  logic             done_c;

  logic [EXP_W-1:0] exp_c;
  logic [EXP_W-1:0] sym_c;
  logic             match_c;
  logic             adv_c;
  logic             run_full_c;
  logic             last_stg_c;
  logic             final_sym_c;

  // Decode of the sampled symbol against the current stage expectation
  always_comb begin
    exp_c       = EXP_W'(stg) + EXP_W'(1);
    sym_c       = {1'b0, num};
    run_full_c  = (run == RUN_W'(RUN_MIN));
    last_stg_c  = (32'(stg) == STAGES - 1);
    final_sym_c = last_stg_c && ((32'(run) + 1) == RUN_MIN);
    match_c     = (sym_c == exp_c);
    adv_c       = (sym_c == (exp_c + EXP_W'(1))) && run_full_c && !last_stg_c;
  end

  // Next-state logic: match / advance / fail in priority order
  always_comb begin
    stg_n  = stg;
    run_n  = run;
    done_c = 1'b0;
    if (en) begin
      if (match_c && !(strict && run_full_c)) begin
        if (final_sym_c) begin
          done_c = 1'b1;
          stg_n  = '0;
          run_n  = '0;
        end else if (!run_full_c) begin
          run_n = run + RUN_W'(1);
        end
      end else if (!match_c && adv_c) begin
        stg_n = stg + STG_W'(1);
        run_n = RUN_W'(1);
      end else begin
        // A '1' restarts the pattern and counts as its first symbol
        stg_n = '0;
        run_n = (num == SYM_W'(1)) ? RUN_W'(1) : '0;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg       <= '0;
      run       <= '0;
      ans       <= 1'b0;
      hit_cnt   <= '0;
      cur_stage <= '0;
    end else begin
      stg       <= stg_n;
      run       <= run_n;
      ans       <= done_c;
      cur_stage <= stg_n;
      if (clr) begin
        hit_cnt <= '0;
      end else if (done_c && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + CNT_W'(1);
      end
    end
  end

endmodule
